// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-and-add multiplier, signed/unsigned, fixed latency
// Operands are held as magnitudes; the sign is applied once, on the final CALC edge.
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = PW + BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state_q,  state_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [ACC_W-1:0]          acc_q,    acc_d;
    logic [PW-1:0]             mcand_q,  mcand_d;
    logic [WIDTH-1:0]          mplier_q, mplier_d;
    logic                      neg_q,    neg_d;
    logic [PW-1:0]             result_q, result_d;

    logic [WIDTH-1:0]          a_mag;
    logic [WIDTH-1:0]          b_mag;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [ACC_W-1:0]          partial;
    logic [ACC_W-1:0]          acc_sum;
    logic [PW-1:0]             prod_mag;

    always_comb begin
        a_mag    = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag    = (signed_mode && b[WIDTH-1]) ? -b : b;
        digit    = mplier_q[BITS_PER_CYCLE-1:0];
        // mcand_q is pre-shifted to the weight of the current digit
        partial  = ACC_W'(mcand_q) * ACC_W'(digit);
        acc_sum  = acc_q + partial;
        prod_mag = acc_sum[PW-1:0];

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    cnt_d    = CNT_W'(N);
                    acc_d    = '0;
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    result_d = neg_q ? -prod_mag : prod_mag;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized and directed bench for seq_multiplier (32x1 and 16x4)
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [31:0] a, b;
    logic [63:0] result;

    logic        in_valid16, in_ready16, signed_mode16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] result16;

    int n_checks = 0;
    int n_pass   = 0;

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .signed_mode(signed_mode16), .out_valid(out_valid16),
        .out_ready(out_ready16), .result(result16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic sm);
        if (sm) return 64'(longint'($signed(x)) * longint'($signed(y)));
        else    return 64'(x) * 64'(y);
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y, input logic sm);
        if (sm) return 32'(int'($signed(x)) * int'($signed(y)));
        else    return 32'(x) * 32'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 32-bit instance; hold = cycles of out_ready=0 in DONE
    task automatic op32(input logic [31:0] ta, input logic [31:0] tb_op, input logic tsm,
                        input logic [63:0] exp, input int hold, input string tag);
        int lat;
        out_ready   = (hold == 0);
        a           = ta;
        b           = tb_op;
        signed_mode = tsm;
        in_valid    = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        // Scribble inputs during CALC; in_valid stays high and must be ignored
        a           = $urandom;
        b           = $urandom;
        signed_mode = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
            if (lat == 3) a = ~a;
        end
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_result"}, result, exp);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_result"}, result, exp);
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_op, input logic tsm,
                        input logic [31:0] exp, input string tag);
        int lat;
        out_ready16   = 1'b0;
        a16           = ta;
        b16           = tb_op;
        signed_mode16 = tsm;
        in_valid16    = 1'b1;
        tick();
        in_valid16 = 1'b0;
        a16        = $urandom;
        b16        = $urandom;
        lat = 0;
        while (!out_valid16 && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_result"}, 64'(result16), 64'(exp));
        out_ready16 = 1'b1;
        tick();
        check({tag, "_post_in_ready"}, 64'(in_ready16), 64'd1);
        check({tag, "_post_result"}, 64'(result16), 64'(exp));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [15:0] ra16, rb16;
        logic [63:0] r0;
        int          seen;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; signed_mode16 = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", result, 64'd0);

        // Reset wins over acceptance on the same edge
        in_valid = 1'b1;
        tick();
        check("rst_prio_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "unsigned_max");
        op32(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, "signed_m3x7");
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, "signed_minxmin");
        op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 0, "signed_minxm1");
        op32(32'd0, 32'd0, 1'b1, 64'd0, 0, "zero");
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, model32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0), 5, "backpressure");

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = $urandom_range(0, 1);
            if (i % 4 == 1) ra = 32'h8000_0000;
            op32(ra, rb, rs, model32(ra, rb, rs), i % 3, "rand32");
        end

        // Abort at CALC cycle 10
        out_ready = 1'b1;
        a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        op32(32'd5, 32'd6, 1'b0, 64'd30, 0, "after_abort");

        // Throughput: back-to-back with in_valid and out_ready high, N+2 cycles apart
        out_ready = 1'b1; in_valid = 1'b1; a = 32'd3; b = 32'd9; signed_mode = 1'b0;
        seen = 0;
        r0 = 0;
        for (int i = 0; i < 2 * 34 + 2; i++) begin
            tick();
            if (out_valid) begin
                if (seen == 1) r0 = 64'(i) - r0;
                else r0 = 64'(i);
                seen++;
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        check("throughput_count", 64'(seen), 64'd2);
        check("throughput_spacing", r0, 64'd34);

        op16(16'd12345, 16'd6789, 1'b0, 32'h04FE_D79D, "w16_directed");
        op16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "w16_minxmin");
        for (int i = 0; i < 10; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            rs   = $urandom_range(0, 1);
            op16(ra16, rb16, rs, model16(ra16, rb16, rs), "rand16");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001: Parameter WIDTH SHALL be declared with default 32; meaning: operand width in bits, legal range 4..64.
REQ-002: Parameter BITS_PER_CYCLE SHALL be declared with default 1; meaning: multiplier bits retired per CALC cycle, legal values 1, 2 or 4, and it must divide WIDTH.
REQ-003: Port clk SHALL be input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004: Port rst_n SHALL be input, 1 bit; reset is synchronous and active-low.
REQ-005: Port in_valid SHALL be input, 1 bit; operands and mode are presented.
REQ-006: Port in_ready SHALL be output, 1 bit; block can accept an operation.
REQ-007: Port a SHALL be input, WIDTH bits; multiplicand.
REQ-008: Port b SHALL be input, WIDTH bits; multiplier.
REQ-009: Port signed_mode SHALL be input, 1 bit; 1 = two's-complement operands, 0 = unsigned operands.
REQ-010: Port out_valid SHALL be output, 1 bit; result is valid.
REQ-011: Port out_ready SHALL be input, 1 bit; consumer accepts the result.
REQ-012: Port result SHALL be output, 2*WIDTH bits; product.
REQ-013: Port busy SHALL be output, 1 bit; high whenever state is not IDLE.

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015: in_ready SHALL be 1 only in IDLE.
REQ-016: Input acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-017: At acceptance, a, b and signed_mode SHALL be captured, the cycle counter SHALL be loaded with N = WIDTH/BITS_PER_CYCLE, and the state SHALL move IDLE->CALC.
REQ-018: While in CALC, later changes on a, b or signed_mode SHALL NOT affect the result.
REQ-019: In signed mode, the operation SHALL use operand magnitudes, perform an unsigned multiply, and apply two's-complement negation to the 2*WIDTH product when exactly one operand is negative.
REQ-020: In unsigned mode, no sign handling SHALL be applied.
REQ-021: Each CALC cycle SHALL consume BITS_PER_CYCLE multiplier bits, LSB first, by shift-and-add.
REQ-022: The accumulator SHALL be at least 2*WIDTH+BITS_PER_CYCLE bits wide so that no intermediate overflow occurs.
REQ-023: Latency SHALL be fixed at N cycles: out_valid SHALL rise exactly N rising edges after the acceptance edge, regardless of operand values (zero operands included).
REQ-024: Sign correction SHALL complete on the CALC->DONE edge and SHALL add no extra cycle.
REQ-025: In DONE, out_valid=1 and result SHALL be held stable until an edge with out_ready=1.
REQ-026: On that edge the state SHALL move DONE->IDLE and out_valid SHALL fall.
REQ-027: Throughput SHALL be one operation per N+2 cycles when in_valid and out_ready are held high; no overlap of operations is permitted.
REQ-028: result SHALL retain the last product after DONE->IDLE until the next DONE.
REQ-029: In signed mode, the boundary case (-2^(WIDTH-1)) * (-2^(WIDTH-1)) SHALL yield +2^(2*WIDTH-2) exactly.
REQ-030: In signed mode, (-2^(WIDTH-1)) * (-1) SHALL yield +2^(WIDTH-1) sign-extended to 2*WIDTH bits.
REQ-031: out_ready asserted outside DONE SHALL be ignored.
REQ-032: in_valid asserted outside IDLE SHALL be ignored, and that operation SHALL NOT be queued.

Reset
REQ-033: On any edge with rst_n=0, the state SHALL become IDLE.
REQ-034: On any edge with rst_n=0, the counter, accumulator and result SHALL be cleared to 0, out_valid SHALL be 0, busy SHALL be 0, and in_ready SHALL be 1 from the following cycle.
REQ-035: Reset SHALL take priority over every other event, including acceptance and result handshake on the same edge.
REQ-036: Reset during CALC or DONE SHALL abort the operation, and no out_valid SHALL be produced for it.

Verification
REQ-037: Unsigned directed test: WIDTH=32, BPC=1, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE00000001, out_valid rising exactly 32 edges after acceptance.
REQ-038: Signed directed test: a=-3 (0xFFFFFFFD), b=7 -> result=0xFFFFFFFFFFFFFFEB.
REQ-039: Signed boundary tests: a=b=0x80000000 -> result=0x4000000000000000; a=0x80000000, b=0xFFFFFFFF -> result=0x0000000080000000.
REQ-040: Backpressure test: out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE on the next edge, in_ready=1.
REQ-041: Mid-operation reset test: rst_n=0 for one edge at CALC cycle 10 -> out_valid=0, result=0, busy=0; a new operation 5*6 then returns 30 with full latency.
REQ-042: Parameter test: WIDTH=16, BPC=4, unsigned, 12345*6789 -> result=83810205 (0x04FED79D), out_valid 4 edges after acceptance.
